ysyx_24080006_hpm: RTL and testbench



---
 rtl/ysyx_24080006_pkg.sv | 39 +++
 rtl/ysyx_24080006_hpm_ctr.sv | 46 ++++
 rtl/ysyx_24080006_hpm.sv | 152 +++++++++++++++
 tb/tb_ysyx_24080006_hpm.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared definitions for the hardware performance monitor: CSR addresses,
// the mhpmevent register layout and the named event lines.
package ysyx_24080006_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCTR3      = 12'hB03;
  localparam logic [11:0] CSR_MHPMCTR3H     = 12'hB83;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_HPMOVF        = 12'h7C0;

  // Only irq_en, edge_mode and index are writable; everything else reads 0.
  localparam logic [31:0] EVT_WMASK = 32'hC000_001F;

  typedef struct packed {
    logic        irq_en;
    logic        edge_mode;
    logic [24:0] rsvd;
    logic [4:0]  index;
  } hpmevent_t;

  typedef enum logic [4:0] {
    EVT_ICACHE_HIT   = 5'd0,
    EVT_ICACHE_MISS  = 5'd1,
    EVT_LOAD         = 5'd2,
    EVT_STORE        = 5'd3,
    EVT_FETCH_CYCLE  = 5'd4
  } evt_idx_e;

  // Counter slot 0 is mcycle, slot 1 minstret, slot 2+k mhpmcounter(3+k);
  // CSR index 1 (time) belongs to a different block, so it is skipped.
  function automatic int slot_to_idx(int slot);
    return (slot == 0) ? 0 : slot + 1;
  endfunction

endpackage

// File: rtl/ysyx_24080006_hpm_ctr.sv
// One counter: split low/high CSR write, increment, and a wrap flag that is
// raised only in a cycle where the increment actually rolls over.
module ysyx_24080006_hpm_ctr
  import ysyx_24080006_pkg::*;
#(
  parameter int CtrWidth = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  input  logic                we_lo,
  input  logic                we_hi,
  input  logic [31:0]         wdata,
  output logic [CtrWidth-1:0] value,
  output logic                wrap
);

  localparam int HiWidth = CtrWidth - 32;

  logic [CtrWidth-1:0] cnt_reg;
  logic [CtrWidth-1:0] cnt_next;

  // A write suppresses both the increment and the overflow in its cycle.
  assign wrap  = inc && !we_lo && !we_hi && (&cnt_reg);
  assign value = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (we_lo) begin
      cnt_next[31:0] = wdata;
    end else if (we_hi) begin
      cnt_next[CtrWidth-1:32] = wdata[HiWidth-1:0];
    end else if (inc) begin
      cnt_next = cnt_reg + CtrWidth'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/ysyx_24080006_hpm.sv
// Machine performance counters: mcycle, minstret and NumHpm event counters
// with inhibit, per-counter event selection, sticky overflow and interrupt.
module ysyx_24080006_hpm
  import ysyx_24080006_pkg::*;
#(
  parameter int NumHpm   = 4,
  parameter int CtrWidth = 64,
  parameter int NumEvt   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NumEvt-1:0] evt,
  input  logic              instret,
  input  logic              csr_we,
  input  logic [11:0]       csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_hit,
  output logic              ovf_irq
);

  localparam int NumCtr  = NumHpm + 2;
  localparam int CsrBits = NumHpm + 3;
  localparam logic [CsrBits-1:0] ImplMask = ~CsrBits'(2);

  logic [CsrBits-1:0]  inhibit_reg;
  logic [CsrBits-1:0]  ovf_reg;
  logic [CsrBits-1:0]  ovf_next;
  logic [CsrBits-1:0]  ovf_clr;
  logic [CsrBits-1:0]  wrap_vec;
  hpmevent_t           event_reg [NumHpm];
  logic [NumEvt-1:0]   evt_prev_reg;
  logic [31:0]         evt_pad;
  logic [31:0]         evt_rise;
  logic [CtrWidth-1:0] ctr_val [NumCtr];
  logic [NumCtr-1:0]   ctr_inc;
  logic [NumCtr-1:0]   ctr_we_lo;
  logic [NumCtr-1:0]   ctr_we_hi;
  logic [NumCtr-1:0]   ctr_wrap;
  logic                ovf_irq_reg;
  logic                irq_next;

  // Padding to 32 makes out-of-range event indices select a constant 0.
  assign evt_pad  = 32'(evt);
  assign evt_rise = 32'(evt & ~evt_prev_reg);

  assign ctr_inc[0] = !inhibit_reg[0];
  assign ctr_inc[1] = instret && !inhibit_reg[2];

  generate
    for (genvar gi = 0; gi < NumHpm; gi++) begin : g_evt
      logic evt_hit;
      assign evt_hit = event_reg[gi].edge_mode ? evt_rise[event_reg[gi].index]
                                               : evt_pad[event_reg[gi].index];
      assign ctr_inc[gi+2] = evt_hit && !inhibit_reg[gi+3];
    end

    for (genvar gi = 0; gi < NumCtr; gi++) begin : g_ctr
      localparam int Idx = slot_to_idx(gi);
      localparam logic [11:0] LoAddr = CSR_MCYCLE + 12'(Idx);
      localparam logic [11:0] HiAddr = CSR_MCYCLEH + 12'(Idx);

      assign ctr_we_lo[gi] = csr_we && (csr_addr == LoAddr);
      assign ctr_we_hi[gi] = csr_we && (csr_addr == HiAddr);
      assign wrap_vec[Idx] = ctr_wrap[gi];

      ysyx_24080006_hpm_ctr #(
        .CtrWidth (CtrWidth)
      ) u_ctr (
        .clock (clock),
        .reset (reset),
        .inc   (ctr_inc[gi]),
        .we_lo (ctr_we_lo[gi]),
        .we_hi (ctr_we_hi[gi]),
        .wdata (csr_wdata),
        .value (ctr_val[gi]),
        .wrap  (ctr_wrap[gi])
      );
    end
  endgenerate

  assign wrap_vec[1] = 1'b0;

  // New overflows win over a same-cycle write-one-to-clear.
  always_comb begin
    ovf_clr = '0;
    if (csr_we && (csr_addr == CSR_HPMOVF)) begin
      ovf_clr = csr_wdata[CsrBits-1:0];
    end
    ovf_next = (ovf_reg & ~ovf_clr) | wrap_vec;
    irq_next = 1'b0;
    for (int k = 0; k < NumHpm; k++) begin
      irq_next = irq_next | (ovf_reg[k+3] & event_reg[k].irq_en);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inhibit_reg  <= '0;
      ovf_reg      <= '0;
      evt_prev_reg <= '0;
      ovf_irq_reg  <= 1'b0;
      for (int k = 0; k < NumHpm; k++) begin
        event_reg[k] <= '0;
      end
    end else begin
      evt_prev_reg <= evt;
      ovf_reg      <= ovf_next;
      ovf_irq_reg  <= irq_next;
      if (csr_we && (csr_addr == CSR_MCOUNTINHIBIT)) begin
        inhibit_reg <= csr_wdata[CsrBits-1:0] & ImplMask;
      end
      for (int k = 0; k < NumHpm; k++) begin
        if (csr_we && (csr_addr == CSR_MHPMEVENT3 + 12'(k))) begin
          event_reg[k] <= csr_wdata & EVT_WMASK;
        end
      end
    end
  end

  assign ovf_irq = ovf_irq_reg;

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    for (int s = 0; s < NumCtr; s++) begin
      if (csr_addr == CSR_MCYCLE + 12'(slot_to_idx(s))) begin
        csr_hit   = 1'b1;
        csr_rdata = ctr_val[s][31:0];
      end
      if (csr_addr == CSR_MCYCLEH + 12'(slot_to_idx(s))) begin
        csr_hit   = 1'b1;
        csr_rdata = 32'(ctr_val[s][CtrWidth-1:32]);
      end
    end
    for (int k = 0; k < NumHpm; k++) begin
      if (csr_addr == CSR_MHPMEVENT3 + 12'(k)) begin
        csr_hit   = 1'b1;
        csr_rdata = event_reg[k];
      end
    end
    if (csr_addr == CSR_MCOUNTINHIBIT) begin
      csr_hit   = 1'b1;
      csr_rdata = 32'(inhibit_reg);
    end
    if (csr_addr == CSR_HPMOVF) begin
      csr_hit   = 1'b1;
      csr_rdata = 32'(ovf_reg);
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_hpm.sv
// Bench for the performance monitor: directed scenarios plus a randomized
// run, all compared against a CSR-level behavioural model.
module tb_ysyx_24080006_hpm;

  localparam int NH = 4;
  localparam int CW = 48;
  localparam int NE = 16;
  localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;
  localparam logic [31:0] IMASK = ((32'd1 << (NH + 3)) - 32'd1) & ~32'd2;

  logic          clock;
  logic          reset;
  logic [NE-1:0] evt;
  logic          instret;
  logic          csr_we;
  logic [11:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_hit;
  logic          ovf_irq;

  int checks   = 0;
  int failures = 0;

  ysyx_24080006_hpm #(
    .NumHpm   (NH),
    .CtrWidth (CW),
    .NumEvt   (NE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .evt       (evt),
    .instret   (instret),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .csr_hit   (csr_hit),
    .ovf_irq   (ovf_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state indexed by CSR counter index i (0, 2, 3..2+NH).
  longint unsigned m_ctr [0:31];
  logic [31:0]     m_sel [0:31];
  logic [31:0]     m_inh;
  logic [31:0]     m_ovf;
  logic [NE-1:0]   m_prev;
  logic            m_irq;

  function automatic bit impl(int i);
    return (i == 0) || (i >= 2 && i <= 2 + NH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_ctr[i] = 0;
      m_sel[i] = 0;
    end
    m_inh  = 0;
    m_ovf  = 0;
    m_prev = 0;
    m_irq  = 0;
  endtask

  // Applies one clock edge worth of architectural rules to the model.
  task automatic model_step();
    logic [31:0]     wraps;
    logic            nirq;
    longint unsigned c;
    bit              inc;
    bit              lvl;
    bit              rise;
    int              idx;
    if (reset) begin
      model_reset();
      return;
    end
    wraps = 0;
    nirq  = 0;
    for (int i = 3; i <= 2 + NH; i++) begin
      if (m_ovf[i] && m_sel[i][31]) nirq = 1;
    end
    for (int i = 0; i < 32; i++) begin
      if (!impl(i)) continue;
      if (i == 0) begin
        inc = !m_inh[0];
      end else if (i == 2) begin
        inc = instret && !m_inh[2];
      end else begin
        idx  = int'(m_sel[i][4:0]);
        lvl  = 0;
        rise = 0;
        if (idx < NE) begin
          lvl  = evt[idx];
          rise = evt[idx] && !m_prev[idx];
        end
        inc = (m_sel[i][30] ? rise : lvl) && !m_inh[i];
      end
      c = m_ctr[i];
      if (csr_we && csr_addr == 12'hB00 + 12'(i)) begin
        c = (c & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
      end else if (csr_we && csr_addr == 12'hB80 + 12'(i)) begin
        c = ((64'(csr_wdata) << 32) | (c & 64'hFFFF_FFFF)) & CMASK;
      end else if (inc) begin
        if (c == CMASK) begin
          c = 0;
          wraps[i] = 1'b1;
        end else begin
          c = c + 1;
        end
      end
      m_ctr[i] = c;
    end
    if (csr_we && csr_addr == 12'h7C0) m_ovf = (m_ovf & ~csr_wdata) | wraps;
    else m_ovf = m_ovf | wraps;
    if (csr_we && csr_addr == 12'h320) m_inh = csr_wdata & IMASK;
    for (int i = 3; i <= 2 + NH; i++) begin
      if (csr_we && csr_addr == 12'h320 + 12'(i)) m_sel[i] = csr_wdata & 32'hC000_001F;
    end
    m_prev = evt;
    m_irq  = nirq;
  endtask

  function automatic logic [31:0] model_read(logic [11:0] a);
    for (int i = 0; i < 32; i++) begin
      if (impl(i)) begin
        if (a == 12'hB00 + 12'(i)) return m_ctr[i][31:0];
        if (a == 12'hB80 + 12'(i)) return m_ctr[i][63:32];
        if (i >= 3 && a == 12'h320 + 12'(i)) return m_sel[i];
      end
    end
    if (a == 12'h320) return m_inh;
    if (a == 12'h7C0) return m_ovf;
    return 32'h0;
  endfunction

  function automatic bit model_hit(logic [11:0] a);
    for (int i = 0; i < 32; i++) begin
      if (impl(i) && (a == 12'hB00 + 12'(i) || a == 12'hB80 + 12'(i))) return 1;
      if (i >= 3 && i <= 2 + NH && a == 12'h320 + 12'(i)) return 1;
    end
    return (a == 12'h320) || (a == 12'h7C0);
  endfunction

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    step();
    csr_we    = 1'b0;
    $display("txn wr addr=%h data=%h", a, d);
  endtask

  task automatic test_reset();
    logic [11:0] ra [0:3] = '{12'hB00, 12'hB80, 12'h320, 12'h7C0};
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    for (int n = 0; n < 4; n++) begin
      csr_addr = ra[n];
      #1;
      checks++;
      if (csr_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", ra[n], csr_rdata, 32'h0);
      end
      $display("txn reset rd addr=%h rdata=%h", ra[n], csr_rdata);
    end
    checks++;
    if (ovf_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", ovf_irq);
    end
    reset = 1'b0;
    step();
    csr_addr = 12'hB00;
    #1;
    checks++;
    if (csr_rdata !== 32'h1 || csr_hit !== 1'b1) begin
      failures++;
      $display("FAIL first_count got=%h hit=%b exp=%h hit=1", csr_rdata, csr_hit, 32'h1);
    end
    $display("txn after reset mcycle=%h", csr_rdata);
  endtask

  task automatic test_mcycle_carry();
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    step();
    csr_addr = 12'hB00;
    #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mcycle_lo_carry got=%h exp=%h", csr_rdata, 32'h0);
    end
    csr_addr = 12'hB80;
    #1;
    checks++;
    if (csr_rdata !== 32'h1) begin
      failures++;
      $display("FAIL mcycle_hi_carry got=%h exp=%h", csr_rdata, 32'h1);
    end
    csr_addr = 12'h7C0;
    #1;
    checks++;
    if (csr_rdata[0] !== 1'b0) begin
      failures++;
      $display("FAIL mcycle_no_ovf got=%b exp=0", csr_rdata[0]);
    end
    $display("txn mcycle carry checked");
  endtask

  task automatic test_event_modes();
    evt = '0;
    wr(12'h323, 32'h0000_0001);
    wr(12'hB03, 32'h0);
    evt = NE'(2);
    repeat (5) step();
    evt = '0;
    step();
    csr_addr = 12'hB03;
    #1;
    checks++;
    if (csr_rdata !== 32'd5) begin
      failures++;
      $display("FAIL level_count got=%0d exp=%0d", csr_rdata, 5);
    end
    wr(12'h323, 32'h4000_0001);
    for (int n = 0; n < 3; n++) begin
      evt = NE'(2);
      step();
      step();
      evt = '0;
      step();
    end
    csr_addr = 12'hB03;
    #1;
    checks++;
    if (csr_rdata !== 32'd8) begin
      failures++;
      $display("FAIL edge_count got=%0d exp=%0d", csr_rdata, 8);
    end
    csr_addr = 12'h323;
    #1;
    checks++;
    if (csr_rdata !== 32'h4000_0001) begin
      failures++;
      $display("FAIL event_readback got=%h exp=%h", csr_rdata, 32'h4000_0001);
    end
    $display("txn event modes checked cnt=%0d", 8);
  endtask

  task automatic test_overflow_irq();
    evt = '0;
    wr(12'h324, 32'h8000_0002);
    wr(12'hB04, 32'hFFFF_FFFF);
    wr(12'hB84, 32'hFFFF_FFFF);
    evt = NE'(4);
    step();
    evt = '0;
    csr_addr = 12'hB04;
    #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++;
      $display("FAIL ovf_ctr_lo got=%h exp=%h", csr_rdata, 32'h0);
    end
    csr_addr = 12'hB84;
    #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++;
      $display("FAIL ovf_ctr_hi got=%h exp=%h", csr_rdata, 32'h0);
    end
    csr_addr = 12'h7C0;
    #1;
    checks++;
    if (csr_rdata[4] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%b exp=1", csr_rdata[4]);
    end
    step();
    checks++;
    if (ovf_irq !== 1'b1) begin
      failures++;
      $display("FAIL ovf_irq_set got=%b exp=1", ovf_irq);
    end
    wr(12'h7C0, 32'h10);
    csr_addr = 12'h7C0;
    #1;
    checks++;
    if (csr_rdata[4] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", csr_rdata[4]);
    end
    step();
    checks++;
    if (ovf_irq !== 1'b0) begin
      failures++;
      $display("FAIL ovf_irq_clear got=%b exp=0", ovf_irq);
    end
    // Clear and a fresh wrap in the same cycle: the bit must stay set.
    wr(12'hB84, 32'hFFFF_FFFF);
    wr(12'hB04, 32'hFFFF_FFFF);
    evt = NE'(4);
    wr(12'h7C0, 32'h10);
    evt = '0;
    csr_addr = 12'h7C0;
    #1;
    checks++;
    if (csr_rdata[4] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear_vs_set got=%b exp=1", csr_rdata[4]);
    end
    wr(12'h7C0, 32'hFFFF_FFFF);
    $display("txn overflow irq checked");
  endtask

  task automatic test_write_priority();
    instret = 1'b1;
    wr(12'hB02, 32'd7);
    instret = 1'b0;
    csr_addr = 12'hB02;
    #1;
    checks++;
    if (csr_rdata !== 32'd7) begin
      failures++;
      $display("FAIL write_vs_inc got=%0d exp=%0d", csr_rdata, 7);
    end
    $display("txn minstret=%0d", csr_rdata);
  endtask

  task automatic test_inhibit();
    longint unsigned snap [0:31];
    logic [11:0] ra [0:4] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05};
    int          ri [0:4] = '{0, 2, 3, 4, 5};
    wr(12'h320, 32'h1D);
    for (int i = 0; i < 32; i++) snap[i] = m_ctr[i];
    evt     = '1;
    instret = 1'b1;
    repeat (10) step();
    evt     = '0;
    instret = 1'b0;
    for (int n = 0; n < 5; n++) begin
      csr_addr = ra[n];
      #1;
      checks++;
      if (ri[n] == 5) begin
        if (csr_rdata !== 32'(snap[5] + 10)) begin
          failures++;
          $display("FAIL inhibit_free addr=%h got=%h exp=%h", ra[n], csr_rdata, 32'(snap[5] + 10));
        end
      end else if (csr_rdata !== snap[ri[n]][31:0]) begin
        failures++;
        $display("FAIL inhibit_hold addr=%h got=%h exp=%h", ra[n], csr_rdata, snap[ri[n]][31:0]);
      end
    end
    csr_addr = 12'h320;
    #1;
    checks++;
    if (csr_rdata !== 32'h1D) begin
      failures++;
      $display("FAIL inhibit_read got=%h exp=%h", csr_rdata, 32'h1D);
    end
    wr(12'h320, 32'hFFFF_FFFF);
    csr_addr = 12'h320;
    #1;
    checks++;
    if (csr_rdata !== 32'h7D) begin
      failures++;
      $display("FAIL inhibit_mask got=%h exp=%h", csr_rdata, 32'h7D);
    end
    wr(12'h320, 32'h0);
    $display("txn inhibit checked");
  endtask

  task automatic test_unmapped();
    logic [11:0] ua [0:5] = '{12'h123, 12'hB01, 12'hB07, 12'hB87, 12'h327, 12'h7C1};
    for (int n = 0; n < 6; n++) begin
      csr_addr = ua[n];
      #1;
      checks++;
      if (csr_hit !== 1'b0 || csr_rdata !== 32'h0) begin
        failures++;
        $display("FAIL unmapped addr=%h got=%h hit=%b exp=0 hit=0", ua[n], csr_rdata, csr_hit);
      end
    end
    step();
    csr_addr = 12'h326;
    #1;
    checks++;
    if (csr_hit !== 1'b1) begin
      failures++;
      $display("FAIL last_event_hit got=%b exp=1", csr_hit);
    end
    wr(12'hB01, 32'hDEAD_BEEF);
    csr_addr = 12'hB86;
    #1;
    checks++;
    if (csr_hit !== 1'b1 || csr_rdata !== model_read(12'hB86)) begin
      failures++;
      $display("FAIL last_ctr_hi got=%h hit=%b exp=%h hit=1", csr_rdata, csr_hit, model_read(12'hB86));
    end
    $display("txn unmapped checked");
  endtask

  task automatic test_random();
    logic [11:0] addrs [0:24] = '{
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
      12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'h320, 12'h323, 12'h324, 12'h325,
      12'h326, 12'h7C0, 12'hB01, 12'hB81, 12'hB07, 12'hB87, 12'h321, 12'h327,
      12'h123};
    for (int n = 0; n < 400; n++) begin
      logic [11:0] ra;
      logic [31:0] er;
      bit          eh;
      ra       = addrs[$urandom_range(0, 24)];
      csr_we   = 1'b0;
      csr_addr = ra;
      #1;
      er = model_read(ra);
      eh = model_hit(ra);
      checks++;
      if (csr_rdata !== er || csr_hit !== eh) begin
        failures++;
        $display("FAIL rnd_read n=%0d addr=%h got=%h hit=%b exp=%h hit=%b", n, ra, csr_rdata, csr_hit, er, eh);
      end
      checks++;
      if (ovf_irq !== m_irq) begin
        failures++;
        $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, ovf_irq, m_irq);
      end
      $display("txn rnd n=%0d addr=%h rdata=%h hit=%b irq=%b", n, ra, csr_rdata, csr_hit, ovf_irq);
      evt      = NE'($urandom);
      instret  = 1'($urandom_range(0, 1));
      csr_we   = ($urandom_range(0, 3) == 0);
      csr_addr = addrs[$urandom_range(0, 24)];
      case ($urandom_range(0, 2))
        0:       csr_wdata = $urandom;
        1:       csr_wdata = 32'hFFFF_FFFF;
        default: csr_wdata = 32'hFFFF_FFF0;
      endcase
      if (csr_addr == 12'h320) csr_wdata = $urandom & 32'h0000_0035;
      if (csr_addr >= 12'h323 && csr_addr <= 12'h326)
        csr_wdata = ($urandom & 32'hC000_0000) | 32'($urandom_range(0, 19));
      step();
    end
    csr_we  = 1'b0;
    evt     = '0;
    instret = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] ra [0:4] = '{12'hB00, 12'hB02, 12'h320, 12'h7C0, 12'h323};
    evt       = '1;
    csr_we    = 1'b1;
    csr_addr  = 12'hB03;
    csr_wdata = 32'd5;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (csr_rdata !== 32'h0 || ovf_irq !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h irq=%b exp=0 irq=0", csr_rdata, ovf_irq);
    end
    @(posedge clock);
    #1;
    checks++;
    if (csr_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_beats_write got=%h exp=%h", csr_rdata, 32'h0);
    end
    csr_we = 1'b0;
    for (int n = 0; n < 5; n++) begin
      csr_addr = ra[n];
      #1;
      checks++;
      if (csr_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid_read addr=%h got=%h exp=%h", ra[n], csr_rdata, 32'h0);
      end
    end
    evt   = '0;
    reset = 1'b0;
    $display("txn reset mid-count checked");
  endtask

  initial begin
    reset     = 1'b1;
    evt       = '0;
    instret   = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = 12'h0;
    csr_wdata = 32'h0;
    test_reset();
    test_mcycle_carry();
    test_event_modes();
    test_overflow_irq();
    test_write_priority();
    test_inhibit();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
